// File: rtl/weight_loader.sv
// weight_loader: packs column-major weight words into NROW-wide columns and writes one RAM column per NROW words.
// Ports:
//   clk, reset (async, active-low)
//   start                 request a full NCOL-column load (ignored unless idle)
//   in_data/in_valid      word stream, consumed when in_ready is high
//   in_ready              high only while collecting a column
//   wr_en/wr_addr/wr_data one-cycle column write to the weight RAM
//   busy                  high from start acceptance until back in idle
//   done                  one-cycle pulse after the last column write
module weight_loader #(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int BITWIDTH      = 18,
  parameter int ADDR_BITWIDTH = 4,
  parameter int ROW_BITWIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BITWIDTH-1:0]        in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [ADDR_BITWIDTH-1:0]   wr_addr,
  output logic [NROW*BITWIDTH-1:0]   wr_data,
  output logic                       busy,
  output logic                       done
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [ROW_BITWIDTH-1:0]  row;
  logic [ADDR_BITWIDTH-1:0] col;
  logic [NROW*BITWIDTH-1:0] pack, pack_nx;
  logic take, last_row, last_col;
  assign take     = (state == LOAD) && in_valid;
  assign last_row = row == ROW_BITWIDTH'(NROW - 1);
  assign last_col = col == ADDR_BITWIDTH'(NCOL - 1);
  always_comb begin
    pack_nx = pack;
    pack_nx[row*BITWIDTH +: BITWIDTH] = in_data;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = (take && last_row) ? WRITE : LOAD;
      WRITE:   state_nx = last_col ? DONE : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  // wr_data is its own register, loaded together with the final word of a
  // column, so it stays stable while the next column is being packed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      pack    <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end
      if (take) begin
        pack <= pack_nx;
        row  <= last_row ? '0 : row + 1'b1;
        if (last_row) wr_data <= pack_nx;
      end
      if (state == WRITE) col <= last_col ? '0 : col + 1'b1;
    end
  end
  assign in_ready = state == LOAD;
  assign wr_en    = state == WRITE;
  assign wr_addr  = col;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
endmodule
